wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter for the single write port of the 8×16 register file inside `rd_wr_unit`. It shares that port between two producers, the ALU result path and the memory-load path. Memory loads have priority. ALU results are buffered in a small FIFO, and a starvation counter guarantees ALU progress. The block drives `wreg`/`wd`/`skip` into `rd_wr_unit` and exports a pending-write mask for decode-stage hazard detection.

## Interface
- `DEPTH`, 2: ALU FIFO entries; power of two, ≥2.
- `MAX_WAIT`, 3: consecutive cycles a non-empty FIFO may lose to memory before ALU is forced; 1..15.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result offered.
- `alu_ready`  out  1  FIFO can accept; `= !full` (combinational).
- `alu_reg`  in  3  ALU destination register.
- `alu_data`  in  16  ALU result.
- `mem_valid`  in  1  load result offered.
- `mem_ready`  out  1  load accepted this cycle; `= !force_alu` (combinational).
- `mem_reg`  in  3  load destination register.
- `mem_data`  in  16  load data.
- `wreg`  out  3  registered write address to `rd_wr_unit`.
- `wd`  out  16  registered write data.
- `skip`  out  1  registered; 1 = no write this cycle.
- `busy`  out  8  bit r set while a write to r is queued or in the output stage.

## Operation
- Transfer rule: ALU transfers on `alu_valid && alu_ready`. Memory transfers on `mem_valid && mem_ready`.
- FIFO: an accepted ALU result is enqueued at the tail. The head becomes eligible the cycle after enqueue; there is no bypass.
- Selection each cycle, in priority order:
  1. `force_alu` and FIFO non-empty → grant ALU head.
  2. `mem_valid` → grant memory.
  3. FIFO non-empty → grant ALU head.
  4. Otherwise idle.
- Grant effect: the winner loads `wreg`/`wd` with `skip=0`. Idle loads `skip=1`, and `wreg`/`wd` hold their values. An ALU grant dequeues the head.
- Starvation counter `wait_cnt` (4 bits):
  - Increments when the FIFO is non-empty and memory wins.
  - Clears on any ALU grant, and whenever the FIFO is empty.
  - `force_alu = (wait_cnt == MAX_WAIT) && !empty`.
- `busy` is the OR of one-hot(`alu_reg`) over valid FIFO entries, plus one-hot(`wreg`) when `skip=0`. It is combinational from registered state only.
- Full/empty: `full` when count == DEPTH. A simultaneous enqueue and dequeue at full is impossible because `alu_ready=0` at full. At count DEPTH−1, an enqueue and a dequeue in the same cycle leaves the count unchanged.
- Pointers wrap modulo DEPTH. The count is `$clog2(DEPTH)+1` bits wide.

## Timing
- Memory: accepted in cycle N → `skip=0`, `wreg`/`wd` valid in N+1 → register file written at the end of N+1.
- ALU, uncontended: enqueued in N → granted in N+1 → output in N+2.
- Worst case ALU wait after reaching the head: MAX_WAIT+1 cycles.
- Reset values: `skip=1`, `wreg=0`, `wd=0`, FIFO empty, `wait_cnt=0`, `busy=0`. This gives `alu_ready=1` and `mem_ready=1` in the first cycle after reset.
- Reset mid-operation: all queued and in-flight writes are discarded, and no write is issued in the cycle after reset.

## Configuration
- `WB_DROP_R0_EN` defined:
  - A grant whose destination is r0 still dequeues or accepts normally but produces `skip=1`.
  - Bit 0 of `busy` is forced to 0.
- `WB_DROP_R0_EN` undefined: r0 is written like any other register.

## Structure
- Shared package holds `REG_W=3`, `DATA_W=16`, `NUM_REGS=8`, and a `wb_req_t` struct (`reg`, `data`) used by the FIFO and the output stage.
- One sub-module, `wb_fifo`: a parameterised synchronous FIFO with `full`/`empty`/`count` and a per-entry valid/reg view for the `busy` computation.
- Arbitration, the starvation counter and the output register stay in `wb_arbiter`.

## Test plan
- **Reset:** hold `rst` for 2 cycles with both requesters valid → `skip=1`, `busy=0`, no write. After release, `alu_ready=1` and `mem_ready=1`.
- **Lone ALU:** ALU reg 3, data 0x1234 at cycle N → `busy[3]=1` from N+1; `wreg=3`, `wd=0x1234`, `skip=0` at N+2; `busy=0` at N+3.
- **Simultaneous requests:** mem reg 5/0xAAAA and ALU reg 2/0x5555 both at N → mem written at N+1, ALU at N+2.
- **Starvation, MAX_WAIT=3:** continuous `mem_valid` plus one ALU entry → 3 mem writes, then `mem_ready=0` for one cycle and the ALU write, then mem resumes.
- **Full FIFO:** continuous ALU and memory input, DEPTH=2 → `alu_ready` drops after 2 enqueues, and no entry is lost or duplicated (compare the write sequence against a scoreboard).
- **R0 with `WB_DROP_R0_EN`:** ALU reg 0 → dequeued, `skip` stays 1, `busy[0]` stays 0. Without the macro → a write to r0 occurs.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared types and widths for the write-back arbiter
//
// Contents:
//   REG_W      register address width
//   DATA_W     register data width
//   NUM_REGS   number of architectural registers
//   wb_req_t   one pending register write (destination + data)
//   reg_onehot decode of a register number into a NUM_REGS-wide mask
package wb_arbiter_pkg;

   localparam int REG_W    = 3;
   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 8;

   // "reg" is a reserved word, so the destination field is named rnum.
   typedef struct packed {
      logic [REG_W-1:0]  rnum;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
      return NUM_REGS'(1) << r;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO buffering ALU write-back requests
//
// Parameters:
//   DEPTH        number of entries (power of two, >= 2)
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset (empties the FIFO)
//   push         enqueue push_req at the tail (ignored when full)
//   push_req     request to enqueue
//   pop          dequeue the head (ignored when empty)
//   head         request at the head of the FIFO
//   full         count == DEPTH
//   empty        count == 0
//   count        number of valid entries
//   entry_valid  per storage slot: slot holds a queued request
//   entry_reg    per storage slot: destination register of that slot
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push,
   input  wb_req_t                          push_req,
   input  logic                             pop,
   output wb_req_t                          head,
   output logic                             full,
   output logic                             empty,
   output logic [$clog2(DEPTH):0]           count,
   output logic [DEPTH-1:0]                 entry_valid,
   output logic [DEPTH-1:0][REG_W-1:0]      entry_reg
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_req_t          slots [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] offs;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = slots[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) slots[wr_ptr] <= push_req;
   end

   // A slot is live when its distance from the read pointer is below count.
   always_comb begin
      offs        = '0;
      entry_valid = '0;
      entry_reg   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs           = PTR_W'(i) - rd_ptr;
         entry_valid[i] = ({1'b0, offs} < count);
         entry_reg[i]   = slots[i].rnum;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter for the register file write port
//
// Shares the single register-file write port between the memory-load path
// (priority) and the ALU result path (buffered in wb_fifo). A starvation
// counter forces an ALU grant after MAX_WAIT consecutive memory wins.
//
// Optional feature macro: WB_DROP_R0_EN
//   defined   - grants targeting r0 are consumed but never written; busy[0]=0
//   undefined - r0 is written like any other register
//
// Parameters:
//   DEPTH      ALU FIFO entries (power of two, >= 2)
//   MAX_WAIT   memory wins tolerated against a non-empty FIFO (1..15)
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   alu_valid  ALU result offered
//   alu_ready  FIFO can accept (!full)
//   alu_reg    ALU destination register
//   alu_data   ALU result
//   mem_valid  load result offered
//   mem_ready  load accepted this cycle (!force_alu)
//   mem_reg    load destination register
//   mem_data   load data
//   wreg       registered write address
//   wd         registered write data
//   skip       registered, 1 = no write this cycle
//   busy       per-register pending-write mask (FIFO + output stage)
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alu_valid,
   output logic                 alu_ready,
   input  logic [REG_W-1:0]     alu_reg,
   input  logic [DATA_W-1:0]    alu_data,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic [REG_W-1:0]     mem_reg,
   input  logic [DATA_W-1:0]    mem_data,
   output logic [REG_W-1:0]     wreg,
   output logic [DATA_W-1:0]    wd,
   output logic                 skip,
   output logic [NUM_REGS-1:0]  busy
);

`ifdef WB_DROP_R0_EN
   localparam bit DROP_R0 = 1'b1;
`else
   localparam bit DROP_R0 = 1'b0;
`endif

   wb_req_t                      head;
   wb_req_t                      alu_req;
   wb_req_t                      sel_req;
   logic                         full;
   logic                         empty;
   logic [$clog2(DEPTH):0]       count;
   logic [DEPTH-1:0]             entry_valid;
   logic [DEPTH-1:0][REG_W-1:0]  entry_reg;
   logic [3:0]                   wait_cnt;
   logic                         force_alu;
   logic                         grant_alu;
   logic                         grant_mem;
   logic                         alu_push;

   assign alu_req   = '{rnum: alu_reg, data: alu_data};
   assign force_alu = (wait_cnt == 4'(MAX_WAIT)) && !empty;
   assign alu_ready = !full;
   assign mem_ready = !force_alu;
   assign alu_push  = alu_valid && alu_ready;

   // Memory wins unless the FIFO head is being forced; an idle memory side
   // lets the FIFO head through.
   assign grant_alu = !empty && (force_alu || !mem_valid);
   assign grant_mem = mem_valid && !force_alu;
   assign sel_req   = grant_alu ? head : '{rnum: mem_reg, data: mem_data};

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (alu_push),
      .push_req    (alu_req),
      .pop         (grant_alu),
      .head        (head),
      .full        (full),
      .empty       (empty),
      .count       (count),
      .entry_valid (entry_valid),
      .entry_reg   (entry_reg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wreg     <= '0;
         wd       <= '0;
         skip     <= 1'b1;
         wait_cnt <= '0;
      end else begin
         if (grant_alu || grant_mem) begin
            wreg <= sel_req.rnum;
            wd   <= sel_req.data;
            skip <= DROP_R0 && (sel_req.rnum == '0);
         end else begin
            skip <= 1'b1;
         end

         // Counts memory wins only while an ALU entry is waiting.
         if (empty || grant_alu)
            wait_cnt <= '0;
         else if (grant_mem)
            wait_cnt <= wait_cnt + 4'd1;
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i]) busy = busy | reg_onehot(entry_reg[i]);
      end
      if (!skip) busy = busy | reg_onehot(wreg);
`ifdef WB_DROP_R0_EN
      busy[0] = 1'b0;
`endif
   end

   logic unused_count;
   assign unused_count = ^count;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking scoreboard bench for wb_arbiter
module tb_wb_arbiter;

   localparam int DEPTH    = 2;
   localparam int MAX_WAIT = 3;

   typedef struct packed {
      logic [2:0]  r;
      logic [15:0] d;
   } ent_t;

   typedef struct packed {
      logic        skip;
      logic [2:0]  r;
      logic [15:0] d;
      logic [7:0]  busy;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [2:0]  alu_reg = '0;
   logic [15:0] alu_data = '0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [2:0]  mem_reg = '0;
   logic [15:0] mem_data = '0;
   logic [2:0]  wreg;
   logic [15:0] wd;
   logic        skip;
   logic [7:0]  busy;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   ent_t mq [$];
   exp_t exp_q [$];
   int   m_wait = 0;
   logic m_skip = 1'b1;
   logic [2:0]  m_wreg = '0;
   logic [15:0] m_wd = '0;
   int   mem_stalls = 0;
   int   alu_stalls = 0;

   wb_arbiter #(
      .DEPTH    (DEPTH),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_reg   (alu_reg),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_reg   (mem_reg),
      .mem_data  (mem_data),
      .wreg      (wreg),
      .wd        (wd),
      .skip      (skip),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic drop_r0(input logic [2:0] r);
`ifdef WB_DROP_R0_EN
      return (r == 3'd0);
`else
      return 1'b0;
`endif
   endfunction

   // One clock cycle: drive, predict, push expectation, clock, pop and compare.
   task automatic cyc(input logic r, input logic av, input logic [2:0] ar, input logic [15:0] ad,
                      input logic mv, input logic [2:0] mr, input logic [15:0] md);
      logic force_a, had, acc_a, g_alu, g_mem;
      ent_t e;
      exp_t x, got;
      @(negedge clk);
      rst = r; alu_valid = av; alu_reg = ar; alu_data = ad;
      mem_valid = mv; mem_reg = mr; mem_data = md;
      #1;
      if (r) begin
         mq.delete();
         m_wait = 0; m_skip = 1'b1; m_wreg = '0; m_wd = '0;
      end else begin
         force_a = (m_wait == MAX_WAIT) && (mq.size() > 0);
         chk("alu_ready", 32'(alu_ready), 32'(mq.size() < DEPTH));
         chk("mem_ready", 32'(mem_ready), 32'(!force_a));
         if (mv && !mem_ready) mem_stalls++;
         if (!alu_ready) alu_stalls++;
         had   = mq.size() > 0;
         acc_a = av && (mq.size() < DEPTH);
         g_alu = had && (force_a || !mv);
         g_mem = !g_alu && mv;
         if (g_alu) begin
            e = mq.pop_front();
            m_wreg = e.r; m_wd = e.d; m_skip = drop_r0(e.r);
         end else if (g_mem) begin
            m_wreg = mr; m_wd = md; m_skip = drop_r0(mr);
         end else begin
            m_skip = 1'b1;
         end
         if (!had || g_alu) m_wait = 0;
         else if (g_mem) m_wait++;
         if (acc_a) mq.push_back('{r: ar, d: ad});
      end
      x.skip = m_skip; x.r = m_wreg; x.d = m_wd; x.busy = '0;
      foreach (mq[i]) x.busy[mq[i].r] = 1'b1;
      if (!m_skip) x.busy[m_wreg] = 1'b1;
`ifdef WB_DROP_R0_EN
      x.busy[0] = 1'b0;
`endif
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      chk("skip", 32'(skip), 32'(got.skip));
      chk("busy", 32'(busy), 32'(got.busy));
      if (!got.skip) begin
         chk("wreg", 32'(wreg), 32'(got.r));
         chk("wd", 32'(wd), 32'(got.d));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
   endtask

   initial begin
      // Reset with both requesters active
      cyc(1'b1, 1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
      cyc(1'b1, 1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
      chk("rst_wreg", 32'(wreg), 32'd0);
      chk("rst_wd", 32'(wd), 32'd0);
      chk("rst_skip", 32'(skip), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
      #1;
      chk("rst_alu_ready", 32'(alu_ready), 32'd1);
      chk("rst_mem_ready", 32'(mem_ready), 32'd1);

      // Lone ALU write: busy at N+1, write at N+2, clear at N+3
      cyc(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
      chk("lone_busy_n1", 32'(busy), 32'h08);
      cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      chk("lone_wd_n2", 32'(wd), 32'h1234);
      idle(2);

      // Simultaneous: memory first, ALU next
      cyc(1'b0, 1'b1, 3'd2, 16'h5555, 1'b1, 3'd5, 16'hAAAA);
      chk("sim_mem_first", 32'(wd), 32'hAAAA);
      cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      chk("sim_alu_second", 32'(wd), 32'h5555);
      idle(2);

      // Starvation: one ALU entry against continuous loads
      mem_stalls = 0;
      cyc(1'b0, 1'b1, 3'd4, 16'hBEEF, 1'b1, 3'd6, 16'h6000);
      for (int i = 1; i < 10; i++)
         cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'(16'h6000 + i));
      chk("starve_stalls", 32'(mem_stalls), 32'd1);
      idle(3);

      // Full FIFO: continuous ALU and memory traffic
      alu_stalls = 0;
      for (int i = 0; i < 12; i++)
         cyc(1'b0, 1'b1, 3'(i + 1), 16'(16'hA000 + i), 1'b1, 3'(7 - i), 16'(16'hC000 + i));
      chk("full_stall_seen", 32'(alu_stalls > 0), 32'd1);
      idle(6);
      chk("full_drained", 32'(busy), 32'd0);

      // Register 0 destination
      cyc(1'b0, 1'b1, 3'd0, 16'h0F0F, 1'b0, 3'd0, 16'h0);
      cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
`ifdef WB_DROP_R0_EN
      chk("r0_dropped", 32'(skip), 32'd1);
`else
      chk("r0_written", 32'(skip), 32'd0);
`endif
      idle(2);

      // Reset mid-operation discards queued work
      cyc(1'b0, 1'b1, 3'd1, 16'h0101, 1'b1, 3'd2, 16'h0202);
      cyc(1'b0, 1'b1, 3'd3, 16'h0303, 1'b1, 3'd4, 16'h0404);
      cyc(1'b1, 1'b1, 3'd5, 16'h0505, 1'b1, 3'd6, 16'h0606);
      chk("midrst_skip", 32'(skip), 32'd1);
      idle(3);

      // Random traffic
      for (int i = 0; i < 400; i++)
         cyc(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
             1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom));
      idle(8);
      chk("final_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
